// File: rtl/axis_beat_pkg.sv
// axis_beat_pkg: state encoding and beat address increment shared by the axis_beat slice.
package axis_beat_pkg;

    localparam int IDLE = 0;
    localparam int BEAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'(1 << IDLE),
        ST_BEAT = 2'(1 << BEAT)
    } state_e;

    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// axis_beat_fifo: synchronous power-of-two command FIFO with registered full/empty flags.
module axis_beat_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  push, pop;

    always_comb begin
        push    = push_i & ~full_q;
        pop     = pop_i & ~empty_q;
        wr_d    = wr_q + DEPTH_LOG2'(push);
        rd_d    = rd_q + DEPTH_LOG2'(pop);
        full_d  = (push & ~pop) ? (wr_d == rd_q) : (pop & ~push) ? 1'b0 : full_q;
        empty_d = (pop & ~push) ? (rd_d == wr_q) : (push & ~pop) ? 1'b0 : empty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/axis_beat.sv
// axis_beat: splits queued AXI address commands into per-beat addresses with last/done flags,
// chaining bursts back to back without bubbles.
module axis_beat
    import axis_beat_pkg::*;
#(
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int CMD_DEPTH_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
    input  logic [AXI_LEN_WIDTH-1:0]  axi_alen,
    input  logic                      axi_avalid,
    output logic                      axi_aready,
    output logic [AXI_ADDR_WIDTH-1:0] beat_addr,
    output logic                      beat_last,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic                      burst_done,
    output logic                      busy
);

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_INC = AXI_ADDR_WIDTH'(beat_bytes(AXI_DATA_WIDTH));

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d, head_addr;
    logic [AXI_LEN_WIDTH-1:0]  cnt_q, cnt_d, head_len;
    logic                      done_q, done_d;
    logic                      fifo_full, fifo_empty, pop, accept;

    axis_beat_fifo #(
        .WIDTH      (AXI_ADDR_WIDTH + AXI_LEN_WIDTH),
        .DEPTH_LOG2 (CMD_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (axi_avalid),
        .data_i  ({axi_aaddr, axi_alen}),
        .pop_i   (pop),
        .data_o  ({head_addr, head_len}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A completing last beat may pop the next command on the same edge.
    always_comb begin
        accept  = state_q[BEAT] & beat_ready;
        pop     = ~fifo_empty & (state_q[IDLE] | (accept & beat_last));
        state_d = pop ? ST_BEAT : (accept & beat_last) ? ST_IDLE : state_q;
        addr_d  = pop ? head_addr : (accept & ~beat_last) ? addr_q + ADDR_INC : addr_q;
        cnt_d   = pop ? head_len : (accept & ~beat_last) ? cnt_q - 1'b1 : cnt_q;
        done_d  = accept & beat_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        cnt_q  <= cnt_d;
    end

    assign axi_aready = ~fifo_full;
    assign beat_addr  = addr_q;
    assign beat_last  = (cnt_q == '0);
    assign beat_valid = state_q[BEAT];
    assign burst_done = done_q;
    assign busy       = state_q[BEAT] | ~fifo_empty;

endmodule

// File: tb/tb_axis_beat.sv
// tb_axis_beat: directed vectors with hand-computed expectations for axis_beat.
module tb_axis_beat;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_aaddr;
    logic [7:0]  axi_alen;
    logic        axi_avalid;
    logic        axi_aready;
    logic [31:0] beat_addr;
    logic        beat_last;
    logic        beat_valid;
    logic        beat_ready;
    logic        burst_done;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    axis_beat dut (
        .clk        (clk),
        .rst        (rst),
        .axi_aaddr  (axi_aaddr),
        .axi_alen   (axi_alen),
        .axi_avalid (axi_avalid),
        .axi_aready (axi_aready),
        .beat_addr  (beat_addr),
        .beat_last  (beat_last),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .burst_done (burst_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] l);
        axi_avalid = 1'b1;
        axi_aaddr  = a;
        axi_alen   = l;
        tick();
        axi_avalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; axi_avalid = 1'b0; axi_aaddr = '0; axi_alen = '0; beat_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(beat_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_aready", 32'(axi_aready), 32'd1);
        check("rst_done", 32'(burst_done), 32'd0);

        // four-beat burst, one-cycle latency from push
        beat_ready = 1'b1;
        push(32'h1000, 8'd3);
        check("lat_valid", 32'(beat_valid), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("b4_valid", 32'(beat_valid), 32'd1);
            check("b4_addr", beat_addr, 32'h1000 + 32'(i) * 32'h20);
            check("b4_last", 32'(beat_last), 32'(i == 3));
            check("b4_done", 32'(burst_done), 32'd0);
            tick();
        end
        check("b4_done_pulse", 32'(burst_done), 32'd1);
        check("b4_idle", 32'(beat_valid), 32'd0);
        check("b4_notbusy", 32'(busy), 32'd0);
        tick();
        check("b4_done_clear", 32'(burst_done), 32'd0);

        // single beat burst
        push(32'h2000, 8'd0);
        tick();
        check("b1_valid", 32'(beat_valid), 32'd1);
        check("b1_addr", beat_addr, 32'h2000);
        check("b1_last", 32'(beat_last), 32'd1);
        tick();
        check("b1_done", 32'(burst_done), 32'd1);
        check("b1_idle", 32'(beat_valid), 32'd0);

        // two chained bursts without a bubble
        tick();
        axi_avalid = 1'b1; axi_aaddr = 32'h0; axi_alen = 8'd1;
        tick();
        axi_aaddr = 32'h100;
        tick();
        axi_avalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ch_valid", 32'(beat_valid), 32'd1);
            check("ch_addr", beat_addr, (i < 2 ? 32'h0 : 32'h100) + 32'(i % 2) * 32'h20);
            check("ch_last", 32'(beat_last), 32'(i % 2));
            check("ch_done", 32'(burst_done), 32'(i == 2));
            tick();
        end
        check("ch_done_end", 32'(burst_done), 32'd1);
        check("ch_idle", 32'(beat_valid), 32'd0);

        // fill past FIFO depth while stalled, then replay
        beat_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("fill_aready", 32'(axi_aready), 32'd1);
            push(32'h3000 + 32'(i) * 32'h1000, 8'd0);
        end
        check("full_aready", 32'(axi_aready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        check("stall_addr", beat_addr, 32'h3000);
        tick();
        check("stall_hold", beat_addr, 32'h3000);
        check("stall_valid", 32'(beat_valid), 32'd1);
        beat_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("rp_valid", 32'(beat_valid), 32'd1);
            check("rp_addr", beat_addr, 32'h3000 + 32'(i) * 32'h1000);
            check("rp_last", 32'(beat_last), 32'd1);
            tick();
        end
        check("rp_idle", 32'(beat_valid), 32'd0);
        check("rp_aready", 32'(axi_aready), 32'd1);
        tick();

        // address wraps silently
        push(32'hFFFF_FFE0, 8'd1);
        tick();
        check("wr_addr0", beat_addr, 32'hFFFF_FFE0);
        check("wr_last0", 32'(beat_last), 32'd0);
        tick();
        check("wr_addr1", beat_addr, 32'h0000_0000);
        check("wr_last1", 32'(beat_last), 32'd1);
        tick();
        tick();

        // reset mid-burst discards everything
        beat_ready = 1'b0;
        push(32'h5000, 8'd7);
        push(32'h6000, 8'd0);
        push(32'h7000, 8'd0);
        beat_ready = 1'b1;
        tick();
        check("mr_beat2", beat_addr, 32'h5020);
        check("mr_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", 32'(beat_valid), 32'd0);
        check("mr_busy0", 32'(busy), 32'd0);
        check("mr_aready", 32'(axi_aready), 32'd1);
        check("mr_done", 32'(burst_done), 32'd0);
        tick();
        check("mr_done2", 32'(burst_done), 32'd0);
        check("mr_valid2", 32'(beat_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
